pc_flow_ctrl: RTL and testbench
===============================

# pc_flow_ctrl

Fetch-address and exception-redirect controller for the MIPS pipeline. It owns the F-stage PC register and picks the next fetch address each cycle from five sources, in priority order:
- sequential (+4)
- D-stage branch/jump target
- D-stage jr target
- exception/interrupt handler entry
- eret return

A small state machine tracks the exception level (EXL) and the EPC register. It drives the pipeline flush strobes needed for precise exception entry and return.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; F and D hold.
- br_taken  in  1  D-stage branch taken or j/jal decoded.
- br_target  in  32  target for br_taken.
- jr_valid  in  1  D-stage jr/jalr decoded.
- jr_target  in  32  forwarded rs value for jr_valid.
- eret_d  in  1  eret decoded in D.
- exc_m  in  1  synchronous exception flagged on M-stage instruction.
- int_req  in  1  masked external interrupt request, level-sensitive.
- pc_m  in  32  PC of M-stage instruction.
- pc_m_valid  in  1  M stage holds a real instruction, not a bubble.
- bd_m  in  1  M-stage instruction sits in a branch delay slot.
- epc_we  in  1  mtc0 write to EPC, committed from M.
- epc_wdata  in  32  mtc0 write data.
- pc_f  out  32  current fetch address.
- epc  out  32  exception program counter.
- exl  out  1  1 while in handler (state EXL).
- flush_all  out  1  clear F/D, D/E, E/M, M/W pipeline registers at the next edge.
- flush_fd  out  1  clear F/D register only at the next edge.

## Operation
- States: RUN (exl=0) and EXL (exl=1). Reset enters RUN.
- take = (exc_m | int_req) & pc_m_valid & state==RUN.
- Interrupts with pc_m_valid=0 are deferred. int_req stays level and is re-evaluated each cycle. No separate latch.
- Next-PC priority:
  1. reset -> RESET_PC.
  2. take -> HANDLER_PC; epc <= bd_m ? pc_m-4 : pc_m; state -> EXL; flush_all=1.
  3. state==EXL & eret_d & ~stall -> pc_f <= epc; state -> RUN; flush_fd=1, which squashes the instruction fetched behind eret (eret has no delay slot).
  4. stall -> pc_f holds; br/jr/eret are ignored because D re-presents them.
  5. jr_valid -> jr_target.
  6. br_taken -> br_target.
  7. otherwise pc_f+4.
- jr_valid and br_taken asserted together: jr wins. Decoder never asserts both; the bench flags it as an assertion.
- eret_d in RUN is ignored (pc_f+4, no flush).
- exc_m or int_req in EXL is ignored. No nesting.
- epc_we writes epc on the edge unless take is also high that cycle. take wins and the mtc0 is discarded (it is being flushed).
- Arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC+4 = 0.
- bd_m with pc_m=0 gives epc=32'hFFFF_FFFC.
- Targets pass through unaligned. Alignment faults are raised upstream as exc_m.

## Timing
- Reset values: pc_f=RESET_PC, epc=0, exl=0, flush_all=0, flush_fd=0.
- pc_f, epc and exl are registered. flush_all and flush_fd are combinational from current inputs and state, so they act on the same edge that loads the redirect PC.
- Exception entry latency: exc_m high in cycle N gives pc_f=HANDLER_PC and exl=1 in cycle N+1. The handler's first instruction enters D in cycle N+2.
- eret latency: eret_d high in cycle N (not stalled) gives pc_f=epc in N+1 and exl=0 in N+1.
- An interrupt can be taken in cycle N+1 at the earliest.
- Branch/jr redirect is visible on pc_f one cycle after the resolving D cycle. The delay-slot instruction already fetched is not flushed.
- Reset asserted in EXL or mid-stall: next cycle is RUN, pc_f=RESET_PC, epc=0, overriding all other inputs.

## Test plan
- Reset sequencing: reset 2 cycles, release, 3 idle cycles -> pc_f = 3000, 3004, 3008, 300C; epc=0; exl=0.
- Exception in delay slot: exc_m=1, pc_m=3010, bd_m=1, pc_m_valid=1 -> same cycle flush_all=1; next cycle pc_f=4180, epc=300C, exl=1.
- Masking and return: in EXL, int_req=1 and exc_m=1 -> no redirect, pc_f increments. Then eret_d=1 with epc=3020 -> flush_fd=1; next cycle pc_f=3020, exl=0, and the still-high int_req is taken the following cycle.
- Stall versus redirect: stall=1 with br_taken=1, br_target=3100 -> pc_f holds. stall=1 with exc_m=1 -> pc_f=4180 next cycle.
- Deferred interrupt and EPC write: int_req=1 with pc_m_valid=0 for 2 cycles -> no take; pc_m_valid=1, pc_m=3040 -> epc=3040. epc_we=1 together with take -> epc reflects the exception, not epc_wdata.
- Wrap and jr priority: jr_target=FFFF_FFFC -> next pc_f=FFFF_FFFC, then 0000_0000. jr_valid and br_taken together -> jr_target selected, assertion fires.

Source files
------------

// File: rtl/pc_flow_ctrl.sv
// Fetch-address and exception-redirect controller: owns the F-stage PC, the
// EPC register and the exception level, and raises the pipeline flush strobes.
module pc_flow_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        eret_d,
    input  logic        exc_m,
    input  logic        int_req,
    input  logic [31:0] pc_m,
    input  logic        pc_m_valid,
    input  logic        bd_m,
    input  logic        epc_we,
    input  logic [31:0] epc_wdata,
    output logic [31:0] pc_f,
    output logic [31:0] epc,
    output logic        exl,
    output logic        flush_all,
    output logic        flush_fd
);

    typedef enum logic {
        RUN = 1'b0,
        EXL = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] epc_next;
    logic        take;
    logic        eret_go;

    // Interrupts arriving while M holds a bubble are simply retried next cycle.
    assign take    = (exc_m | int_req) & pc_m_valid & (state == RUN);
    assign eret_go = (state == EXL) & eret_d & ~stall;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        pc_next    = pc_f + 32'd4;
        state_next = state;
        epc_next   = epc;
        flush_all  = 1'b0;
        flush_fd   = 1'b0;

        if (take) begin
            pc_next    = HANDLER_PC;
            state_next = EXL;
            flush_all  = ~reset;
        end else if (eret_go) begin
            pc_next    = epc;
            state_next = RUN;
            flush_fd   = ~reset;
        end else if (stall) begin
            pc_next = pc_f;
        end else if (jr_valid) begin
            pc_next = jr_target;
        end else if (br_taken) begin
            pc_next = br_target;
        end

        // A faulting or interrupted instruction in a delay slot restarts at its branch.
        if (take) begin
            epc_next = bd_m ? (pc_m - 32'd4) : pc_m;
        end else if (epc_we) begin
            epc_next = epc_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc_f  <= RESET_PC;
            epc   <= 32'h0000_0000;
        end else begin
            state <= state_next;
            pc_f  <= pc_next;
            epc   <= epc_next;
        end
    end

    assign exl = (state == EXL);

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed self-checking bench for pc_flow_ctrl: reset, exception entry/return,
// masking, stall interaction, deferred interrupts, EPC writes and wrap-around.
module tb_pc_flow_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        eret_d;
    logic        exc_m;
    logic        int_req;
    logic [31:0] pc_m;
    logic        pc_m_valid;
    logic        bd_m;
    logic        epc_we;
    logic [31:0] epc_wdata;
    logic [31:0] pc_f;
    logic [31:0] epc;
    logic        exl;
    logic        flush_all;
    logic        flush_fd;

    int checks = 0;
    int errors = 0;
    int conflict_cnt = 0;

    pc_flow_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .eret_d     (eret_d),
        .exc_m      (exc_m),
        .int_req    (int_req),
        .pc_m       (pc_m),
        .pc_m_valid (pc_m_valid),
        .bd_m       (bd_m),
        .epc_we     (epc_we),
        .epc_wdata  (epc_wdata),
        .pc_f       (pc_f),
        .epc        (epc),
        .exl        (exl),
        .flush_all  (flush_all),
        .flush_fd   (flush_fd)
    );

    always #5 clk = ~clk;

    // The decoder must never present jr and a branch together; flag it when it happens.
    always @(negedge clk) begin
        if (jr_valid && br_taken) begin
            conflict_cnt++;
            $display("assertion: jr_valid and br_taken both high at %0t", $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        jr_valid   = 1'b0;
        jr_target  = 32'h0;
        eret_d     = 1'b0;
        exc_m      = 1'b0;
        int_req    = 1'b0;
        pc_m       = 32'h0;
        pc_m_valid = 1'b0;
        bd_m       = 1'b0;
        epc_we     = 1'b0;
        epc_wdata  = 32'h0;
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp);
        checks++;
        if (pc_f !== exp) begin
            errors++;
            $display("FAIL %s: pc_f=%h expected %h", name, pc_f, exp);
        end
    endtask

    task automatic chk_epc(input string name, input logic [31:0] exp);
        checks++;
        if (epc !== exp) begin
            errors++;
            $display("FAIL %s: epc=%h expected %h", name, epc, exp);
        end
    endtask

    task automatic chk_bits(input string name, input logic exp_exl,
                            input logic exp_fa, input logic exp_ffd);
        checks++;
        if ({exl, flush_all, flush_fd} !== {exp_exl, exp_fa, exp_ffd}) begin
            errors++;
            $display("FAIL %s: exl/flush_all/flush_fd=%b%b%b expected %b%b%b",
                     name, exl, flush_all, flush_fd, exp_exl, exp_fa, exp_ffd);
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        chk_pc("reset_pc", 32'h0000_3000);
        chk_epc("reset_epc", 32'h0);
        chk_bits("reset_flags", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_pc("seq_3004", 32'h0000_3004);
        step();
        chk_pc("seq_3008", 32'h0000_3008);
        step();
        chk_pc("seq_300c", 32'h0000_300C);
        chk_bits("seq_flags", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_exc_delay_slot();
        exc_m = 1'b1; pc_m = 32'h0000_3010; bd_m = 1'b1; pc_m_valid = 1'b1;
        #1;
        chk_bits("exc_flush_same_cycle", 1'b0, 1'b1, 1'b0);
        step();
        idle();
        chk_pc("exc_handler_pc", 32'h0000_4180);
        chk_epc("exc_bd_epc", 32'h0000_300C);
        chk_bits("exc_exl", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mask_eret();
        // In EXL: exception and interrupt ignored, mtc0 to EPC still lands.
        int_req = 1'b1; exc_m = 1'b1; pc_m_valid = 1'b1; pc_m = 32'h0000_3050;
        epc_we = 1'b1; epc_wdata = 32'h0000_3020;
        #1;
        chk_bits("exl_masked_no_flush", 1'b1, 1'b0, 1'b0);
        step();
        chk_pc("exl_masked_inc", 32'h0000_4184);
        chk_epc("exl_mtc0_epc", 32'h0000_3020);
        exc_m = 1'b0; epc_we = 1'b0; eret_d = 1'b1;
        #1;
        chk_bits("eret_flush_fd", 1'b1, 1'b0, 1'b1);
        step();
        eret_d = 1'b0; pc_m = 32'h0000_3060;
        chk_pc("eret_pc", 32'h0000_3020);
        chk_bits("eret_run_int_take", 1'b0, 1'b1, 1'b0);
        step();
        chk_pc("int_after_eret_pc", 32'h0000_4180);
        chk_epc("int_after_eret_epc", 32'h0000_3060);
        chk_bits("int_after_eret_exl", 1'b1, 1'b0, 1'b0);
        idle();
        eret_d = 1'b1;
        step();
        idle();
        chk_pc("eret2_pc", 32'h0000_3060);
        chk_bits("eret2_run", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3100;
        step();
        chk_pc("stall_holds_br", 32'h0000_3060);
        br_taken = 1'b0;
        exc_m = 1'b1; pc_m_valid = 1'b1; pc_m = 32'h0000_3070;
        #1;
        chk_bits("stall_exc_flush", 1'b0, 1'b1, 1'b0);
        step();
        exc_m = 1'b0; pc_m_valid = 1'b0;
        chk_pc("stall_exc_pc", 32'h0000_4180);
        chk_epc("stall_exc_epc", 32'h0000_3070);
        eret_d = 1'b1;
        #1;
        chk_bits("stalled_eret_no_flush", 1'b1, 1'b0, 1'b0);
        step();
        chk_pc("stalled_eret_holds", 32'h0000_4180);
        stall = 1'b0;
        step();
        idle();
        chk_pc("eret_after_stall", 32'h0000_3070);
        chk_bits("eret_after_stall_run", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_deferred_int();
        int_req = 1'b1; pc_m_valid = 1'b0; eret_d = 1'b1;
        #1;
        chk_bits("deferred_no_flush", 1'b0, 1'b0, 1'b0);
        step();
        chk_pc("deferred_1", 32'h0000_3074);
        step();
        chk_pc("deferred_2", 32'h0000_3078);
        eret_d = 1'b0;
        pc_m_valid = 1'b1; pc_m = 32'h0000_3040;
        epc_we = 1'b1; epc_wdata = 32'hDEAD_BEEF;
        #1;
        chk_bits("deferred_take_flush", 1'b0, 1'b1, 1'b0);
        step();
        idle();
        chk_epc("take_beats_mtc0", 32'h0000_3040);
        chk_pc("deferred_handler", 32'h0000_4180);
        eret_d = 1'b1;
        step();
        idle();
        chk_pc("deferred_eret", 32'h0000_3040);
        epc_we = 1'b1; epc_wdata = 32'h1234_5678;
        step();
        idle();
        chk_epc("run_mtc0_epc", 32'h1234_5678);
    endtask

    task automatic test_wrap_jr();
        jr_valid = 1'b1; jr_target = 32'hFFFF_FFFC;
        step();
        idle();
        chk_pc("jr_top", 32'hFFFF_FFFC);
        step();
        chk_pc("wrap_zero", 32'h0000_0000);
        jr_valid = 1'b1; jr_target = 32'h0000_5000;
        br_taken = 1'b1; br_target = 32'h0000_6000;
        step();
        idle();
        chk_pc("jr_beats_br", 32'h0000_5000);
        checks++;
        if (conflict_cnt !== 1) begin
            errors++;
            $display("FAIL conflict_flag: count=%0d expected 1", conflict_cnt);
        end
        br_taken = 1'b1; br_target = 32'h0000_3001;
        step();
        idle();
        chk_pc("br_unaligned", 32'h0000_3001);
        exc_m = 1'b1; pc_m_valid = 1'b1; pc_m = 32'h0; bd_m = 1'b1;
        step();
        idle();
        chk_epc("bd_pc0_epc", 32'hFFFF_FFFC);
        chk_bits("bd_pc0_exl", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_exl();
        reset = 1'b1; stall = 1'b1; eret_d = 1'b1; int_req = 1'b1; pc_m_valid = 1'b1;
        #1;
        chk_bits("reset_blocks_flush", 1'b1, 1'b0, 1'b0);
        step();
        idle();
        reset = 1'b0;
        chk_pc("reset_exl_pc", 32'h0000_3000);
        chk_epc("reset_exl_epc", 32'h0);
        chk_bits("reset_exl_run", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_exc_delay_slot();
        test_mask_eret();
        test_stall();
        test_deferred_int();
        test_wrap_jr();
        test_reset_in_exl();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
